// File: rtl/mure_pkg.sv
// Shared widths, itype encodings and the bundle word stored per retire cycle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mure_pkg;

    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;
    localparam int ITYPE_LEN   = 3;
    localparam int IRETIRE_LEN = 3;

    // Storage is sized for the widest legal configuration; narrower
    // configurations leave the upper slots and bits constant zero.
    localparam int NRET_MAX = 8;
    localparam int XLEN_MAX = 64;

    typedef enum logic [ITYPE_LEN-1:0] {
        ITYPE_NONE = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3
    } itype_e;

    typedef struct packed {
        logic                compressed;
        logic [XLEN_MAX-1:0] pc;
    } slot_t;

    typedef struct packed {
        logic [NRET_MAX-1:0]  valid;
        slot_t [NRET_MAX-1:0] slot;
        logic                 exception;
        logic                 interrupt;
        logic                 eret;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN_MAX-1:0]  tval;
        logic [PRIV_LEN-1:0]  priv;
    } bundle_t;

    // Exception outranks interrupt, interrupt outranks eret.
    function automatic itype_e event_itype(input logic exc, input logic intr, input logic eret);
        if (exc)       return ITYPE_EXC;
        else if (intr) return ITYPE_INT;
        else if (eret) return ITYPE_ERET;
        else           return ITYPE_NONE;
    endfunction

endpackage

// File: rtl/mure_serializer_if.sv
// Commit-side inputs and encoder-side record outputs of the serializer.
// Latency: n/a (wiring only).
// Backpressure: ready_i from the encoder side, overflow reported via overflow_o.
interface mure_serializer_if #(
    parameter int NRET     = 2,
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    import mure_pkg::*;

    logic [NRET-1:0]                valid_i;
    logic [NRET-1:0][XLEN-1:0]      pc_i;
    logic [NRET-1:0][INST_LEN-1:0]  inst_data_i;
    logic [NRET-1:0]                compressed_i;
    logic                           exception_i;
    logic                           interrupt_i;
    logic                           eret_i;
    logic [CAUSE_LEN-1:0]           cause_i;
    logic [XLEN-1:0]                tval_i;
    logic [PRIV_LEN-1:0]            priv_i;
    logic                           ready_i;

    logic                           valid_o;
    logic [IRETIRE_LEN-1:0]         iretire_o;
    logic                           ilastsize_o;
    logic [ITYPE_LEN-1:0]           itype_o;
    logic [CAUSE_LEN-1:0]           cause_o;
    logic [XLEN-1:0]                tval_o;
    logic [PRIV_LEN-1:0]            priv_o;
    logic [XLEN-1:0]                iaddr_o;
    logic                           overflow_o;
    logic [15:0]                    drop_cnt_o;

    // Core/encoder side.
    modport master (
        output valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
               eret_i, cause_i, tval_i, priv_i, ready_i,
        input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
               iaddr_o, overflow_o, drop_cnt_o
    );

    // Serializer side.
    modport slave (
        input  valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
               eret_i, cause_i, tval_i, priv_i, ready_i,
        output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
               iaddr_o, overflow_o, drop_cnt_o
    );

endinterface

// File: rtl/mure_bundle_fifo.sv
// Bundle FIFO: DEPTH entries of dtype, pointer-based, head readable combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller checks full.
module mure_bundle_fifo #(
    parameter int DEPTH = 16,
    parameter type dtype = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  dtype                     wdata,
    output dtype                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    dtype           mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // The extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointers wrap naturally modulo DEPTH through the low AW bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mure_serializer.sv
// Serializes per-cycle retire bundles into one trace record per valid slot (build option MURE_DROP_CNT_EN adds a drop counter).
// Latency: first record of a bundle at least 2 cycles after push; later records back-to-back.
// Backpressure: record held while ready_i=0; bundles arriving at a full FIFO are dropped and flagged.
module mure_serializer
    import mure_pkg::*;
#(
    parameter int NRET        = 2,
    parameter int DEPTH       = 16,
    parameter int XLEN        = 64,
    parameter int INST_LEN    = 32,
    parameter int CAUSE_LEN   = mure_pkg::CAUSE_LEN,
    parameter int PRIV_LEN    = mure_pkg::PRIV_LEN,
    parameter int ITYPE_LEN   = mure_pkg::ITYPE_LEN,
    parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mure_serializer_if.slave bus
);
    typedef enum logic {S_EMPTY, S_SERVE} state_e;

    localparam int SW = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    bundle_t                    wr_bundle;
    bundle_t                    rd_bundle;
    logic                       push_req, push_en, drop, pop, hs;
    logic                       fifo_full, fifo_empty;
    logic [CW-1:0]              fifo_count;
    state_e                     state;
    logic                       serve;
    logic [NRET-1:0]            done;
    logic [NRET-1:0]            rem;
    logic [NRET-1:0]            rest;
    logic [SW-1:0]              cur;
    logic                       has_slot, last;
    slot_t                      cur_slot;
    logic                       overflow;
    logic [NRET-1:0][INST_LEN-1:0] inst_unused;
    logic                       rd_unused;

    // Instruction words are not part of the emitted record.
    assign inst_unused = bus.inst_data_i;
    assign rd_unused   = ^rd_bundle;

    // Pack one retire cycle into a bundle word.
    always_comb begin
        wr_bundle = '0;
        for (int i = 0; i < NRET; i++) begin
            wr_bundle.valid[i]           = bus.valid_i[i];
            wr_bundle.slot[i].compressed = bus.compressed_i[i];
            wr_bundle.slot[i].pc         = XLEN_MAX'(bus.pc_i[i]);
        end
        wr_bundle.exception = bus.exception_i;
        wr_bundle.interrupt = bus.interrupt_i;
        wr_bundle.eret      = bus.eret_i;
        wr_bundle.cause     = bus.cause_i;
        wr_bundle.tval      = XLEN_MAX'(bus.tval_i);
        wr_bundle.priv      = bus.priv_i;
    end

    // A lone eret with no retiring slot carries nothing to trace and is not pushed.
    assign push_req = (|bus.valid_i) | bus.exception_i | bus.interrupt_i;
    assign push_en  = push_req & ~fifo_full;
    assign drop     = push_req &  fifo_full;
    assign serve    = (state == S_SERVE);
    assign hs       = serve & bus.ready_i;
    assign pop      = hs & last;

    mure_bundle_fifo #(
        .DEPTH (DEPTH),
        .dtype (bundle_t)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push_en),
        .pop   (pop),
        .wdata (wr_bundle),
        .rdata (rd_bundle),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Current slot is the lowest valid slot not yet emitted; last when none remain after it.
    always_comb begin
        rem = rd_bundle.valid[NRET-1:0] & ~done;
        cur = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (rem[i]) cur = SW'(i);
        end
        has_slot  = |rem;
        rest      = rem;
        rest[cur] = 1'b0;
        last      = ~|rest;
        cur_slot  = rd_bundle.slot[cur];
    end

    // Output FSM and emitted-slot mask; a pop with more bundles queued stays in SERVE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_EMPTY;
            done  <= '0;
        end else begin
            case (state)
                S_EMPTY: if (!fifo_empty) state <= S_SERVE;
                S_SERVE: begin
                    if (hs) begin
                        if (last) begin
                            done <= '0;
                            if (fifo_count == CW'(1) && !push_en) state <= S_EMPTY;
                        end else begin
                            done <= done | (NRET'(1) << cur);
                        end
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Sticky flag for any bundle lost to a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef MURE_DROP_CNT_EN
    logic [15:0] drop_cnt;

    // Saturating count of dropped bundles.
    always_ff @(posedge clk_i) begin
        if (rst_i)                            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign bus.drop_cnt_o = drop_cnt;
`else
    assign bus.drop_cnt_o = '0;
`endif

    // Record fields decode from registered state only and read zero when idle.
    assign bus.valid_o     = serve;
    assign bus.iretire_o   = (serve && has_slot) ?
                             (cur_slot.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2)) : '0;
    assign bus.ilastsize_o = serve & has_slot & ~cur_slot.compressed;
    assign bus.itype_o     = (serve && last) ?
                             ITYPE_LEN'(event_itype(rd_bundle.exception, rd_bundle.interrupt,
                                                    rd_bundle.eret)) : '0;
    assign bus.iaddr_o     = !serve   ? '0 :
                             has_slot ? XLEN'(cur_slot.pc) : XLEN'(rd_bundle.slot[0].pc);
    assign bus.cause_o     = serve ? CAUSE_LEN'(rd_bundle.cause) : '0;
    assign bus.tval_o      = serve ? XLEN'(rd_bundle.tval) : '0;
    assign bus.priv_o      = serve ? PRIV_LEN'(rd_bundle.priv) : '0;
    assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_mure_serializer.sv
// Directed self-checking bench for mure_serializer at NRET=2, DEPTH=16.
// Latency: records sampled on the falling edge, inputs driven 1ns after the rising edge.
// Backpressure: exercised by holding ready_i low while the FIFO fills past DEPTH.
`timescale 1ns/1ps
module tb_mure_serializer;
    import mure_pkg::*;

    localparam int NRET     = 2;
    localparam int DEPTH    = 16;
    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    // {valid, iretire, ilastsize, itype, cause, tval, priv, iaddr}
    typedef logic [142:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mure_serializer_if #(.NRET(NRET), .XLEN(XLEN), .INST_LEN(INST_LEN)) bus ();

    mure_serializer #(
        .NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .INST_LEN(INST_LEN)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic rec_t mk(input logic v, input logic [2:0] ir, input logic ls,
                                input logic [2:0] it, input logic [4:0] c,
                                input logic [63:0] tv, input logic [1:0] pr,
                                input logic [63:0] ia);
        return {v, ir, ls, it, c, tv, pr, ia};
    endfunction

    function automatic rec_t obs();
        return {bus.valid_o, bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o,
                bus.tval_o, bus.priv_o, bus.iaddr_o};
    endfunction

    task automatic idle();
        bus.valid_i      = '0;
        bus.pc_i         = '0;
        bus.inst_data_i  = '0;
        bus.compressed_i = '0;
        bus.exception_i  = 1'b0;
        bus.interrupt_i  = 1'b0;
        bus.eret_i       = 1'b0;
        bus.cause_i      = '0;
        bus.tval_i       = '0;
        bus.priv_i       = '0;
    endtask

    // Present one bundle for exactly one rising edge.
    task automatic push(input logic [1:0] v, input logic [1:0] cmp,
                        input logic [63:0] p0, input logic [63:0] p1,
                        input logic exc, input logic intr, input logic er,
                        input logic [4:0] c, input logic [63:0] tv, input logic [1:0] pr);
        bus.valid_i        = v;
        bus.compressed_i   = cmp;
        bus.pc_i[0]        = p0;
        bus.pc_i[1]        = p1;
        bus.inst_data_i[0] = 32'h0000_0013;
        bus.inst_data_i[1] = 32'h0000_4501;
        bus.exception_i    = exc;
        bus.interrupt_i    = intr;
        bus.eret_i         = er;
        bus.cause_i        = c;
        bus.tval_i         = tv;
        bus.priv_i         = pr;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rec_t got, exp;
        rst = 1'b1;
        bus.ready_i = 1'b1;
        idle();
        bus.valid_i = 2'b11;
        bus.exception_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_record: got %h expected %h", got, exp);
        end
        vectors++;
        if ({bus.overflow_o, bus.drop_cnt_o} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_overflow: got %b/%h expected 0/0000", bus.overflow_o, bus.drop_cnt_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_inputs_ignored: got valid_o=%b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_two_slots();
        rec_t got, exp;
        bit ok;
        bus.ready_i = 1'b1;
        push(2'b11, 2'b01, 64'h1000, 64'h1002, 0, 0, 0, 5'd0, 64'h0, 2'd3);
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL two_slots_no_bypass: got valid_o=%b expected 0", bus.valid_o);
        end
        wait_valid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL two_slots_timeout: got no valid_o expected valid_o=1");
        end
        exp = mk(1, 3'd1, 0, 3'd0, 5'd0, 64'h0, 2'd3, 64'h1000);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL two_slots_rec0: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd3, 64'h1002);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL two_slots_rec1: got %h expected %h", got, exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL two_slots_end: got valid_o=%b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_exception_slot();
        rec_t got, exp;
        bit ok;
        push(2'b10, 2'b00, 64'h2000, 64'h2004, 1, 0, 0, 5'd2, 64'hDEAD_BEEF, 2'd1);
        wait_valid(ok);
        exp = mk(1, 3'd2, 1, 3'd1, 5'd2, 64'hDEAD_BEEF, 2'd1, 64'h2004);
        got = obs();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL exception_rec: got %h expected %h", got, exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL exception_single: got valid_o=%b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_interrupt_only();
        rec_t got, exp;
        bit ok;
        push(2'b00, 2'b11, 64'h3000, 64'h3008, 0, 1, 0, 5'd7, 64'h55, 2'd3);
        wait_valid(ok);
        exp = mk(1, 3'd0, 0, 3'd2, 5'd7, 64'h55, 2'd3, 64'h3000);
        got = obs();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL interrupt_rec: got %h expected %h", got, exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL interrupt_single: got valid_o=%b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_eret_exception();
        rec_t got, exp;
        bit ok;
        push(2'b11, 2'b00, 64'h4000, 64'h4004, 1, 0, 1, 5'd4, 64'h44, 2'd0);
        wait_valid(ok);
        exp = mk(1, 3'd2, 1, 3'd0, 5'd4, 64'h44, 2'd0, 64'h4000);
        got = obs();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL eret_exc_rec0: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = mk(1, 3'd2, 1, 3'd1, 5'd4, 64'h44, 2'd0, 64'h4004);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL eret_exc_rec1: got %h expected %h", got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rec_t got, exp;
        bit ok;
        bus.ready_i = 1'b1;
        push(2'b01, 2'b00, 64'h5000, 64'h5004, 0, 0, 0, 5'd0, 64'h0, 2'd0);
        push(2'b11, 2'b10, 64'h6000, 64'h6002, 0, 0, 0, 5'd0, 64'h0, 2'd0);
        wait_valid(ok);
        exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd0, 64'h5000);
        got = obs();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL b2b_a0: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd0, 64'h6000);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL b2b_b0: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = mk(1, 3'd1, 0, 3'd0, 5'd0, 64'h0, 2'd0, 64'h6002);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL b2b_b1: got %h expected %h", got, exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got valid_o=%b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_overflow();
        rec_t got, exp;
        logic [15:0] exp_drop;
`ifdef MURE_DROP_CNT_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        bus.ready_i = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            push(2'b01, 2'b00, 64'h7000 + 64'(4 * k), 64'h0, 0, 0, 0, 5'd0, 64'h0, 2'd0);
            @(negedge clk);
            if (k >= 1) begin
                exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd0, 64'h7000);
                got = obs();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL overflow_hold k=%0d: got %h expected %h", k, got, exp);
                end
            end
            if (k == DEPTH - 1) begin
                vectors++;
                if (bus.overflow_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL overflow_early: got %b expected 0", bus.overflow_o);
                end
            end
        end
        vectors++;
        if (bus.overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b expected 1", bus.overflow_o);
        end
        vectors++;
        if (bus.drop_cnt_o !== exp_drop) begin
            miscompares++;
            $display("FAIL drop_cnt: got %h expected %h", bus.drop_cnt_o, exp_drop);
        end
        bus.ready_i = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd0, 64'h7000 + 64'(4 * j));
            got = obs();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL overflow_drain j=%0d: got %h expected %h", j, got, exp);
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus.valid_o, bus.overflow_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL overflow_after_drain: got valid/ovf=%b%b expected 01",
                     bus.valid_o, bus.overflow_o);
        end
    endtask

    task automatic test_reset_mid_bundle();
        rec_t got, exp;
        bit ok;
        bus.ready_i = 1'b0;
        push(2'b11, 2'b00, 64'h8000, 64'h8002, 0, 0, 0, 5'd0, 64'h0, 2'd0);
        wait_valid(ok);
        exp = mk(1, 3'd2, 1, 3'd0, 5'd0, 64'h0, 2'd0, 64'h8000);
        got = obs();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL midrst_rec0: got %h expected %h", got, exp);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.valid_i = 2'b01;
        bus.pc_i[0] = 64'h9000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL midrst_cleared: got %h expected %h", got, exp);
        end
        vectors++;
        if ({bus.overflow_o, bus.drop_cnt_o} !== 17'h0) begin
            miscompares++;
            $display("FAIL midrst_overflow: got %b/%h expected 0/0000", bus.overflow_o, bus.drop_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet c=%0d: got valid_o=%b iaddr=%h expected 0",
                         i, bus.valid_o, bus.iaddr_o);
            end
        end
    endtask

    initial begin
        idle();
        bus.ready_i = 1'b1;
        test_reset();
        test_two_slots();
        test_exception_slot();
        test_interrupt_only();
        test_eret_exception();
        test_back_to_back();
        test_overflow();
        test_reset_mid_bundle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mure_serializer.md
MURE_SERIALIZER -- requirements
Module: mure_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, number of commit ports (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, bundle FIFO depth (power of two, >=2).
REQ-003 SHALL have parameter XLEN, default 64, address/tval width.
REQ-004 SHALL have parameter INST_LEN, default 32, instruction width.
REQ-005 SHALL have parameters CAUSE_LEN 5, PRIV_LEN 2, ITYPE_LEN 3, IRETIRE_LEN 3 as widths of the like-named fields.
REQ-006 SHALL have ports as follows; one clock; reset is synchronous and active-high:
 clk_i  in  1  clock, all state on rising edge
 rst_i  in  1  synchronous active-high reset
 valid_i  in  NRET  per-slot retire valid
 pc_i  in  NRET x XLEN  per-slot PC
 inst_data_i  in  NRET x INST_LEN  per-slot instruction
 compressed_i  in  NRET  per-slot 16-bit instruction flag
 exception_i / interrupt_i / eret_i  in  1 each  cycle event flags
 cause_i  in  CAUSE_LEN;  tval_i  in  XLEN;  priv_i  in  PRIV_LEN  cycle-common fields
 ready_i  in  1  encoder accepts record
 valid_o  out  1  record valid
 iretire_o  out  IRETIRE_LEN;  ilastsize_o  out  1;  itype_o  out  ITYPE_LEN
 cause_o  out  CAUSE_LEN;  tval_o  out  XLEN;  priv_o  out  PRIV_LEN;  iaddr_o  out  XLEN
 overflow_o  out  1  sticky bundle-drop flag
 drop_cnt_o  out  16  dropped-bundle count

Function
REQ-007 SHALL push one bundle (all slots, events, common fields) when (|valid_i | exception_i | interrupt_i) and FIFO not full; full blocks push even if a pop occurs that cycle.
REQ-008 SHALL drop the bundle when the push condition holds and FIFO is full, and set overflow_o on the next cycle; overflow_o stays 1 until reset.
REQ-009 SHALL present first record of a bundle no earlier than cycle after push (1-cycle minimum latency, no bypass).
REQ-010 SHALL emit one record per valid slot, in ascending slot order; invalid slots skipped with zero bubble cycles.
REQ-011 SHALL hold valid_o and all record fields stable while valid_o=1 and ready_i=0.
REQ-012 SHALL advance to next valid slot on valid_o & ready_i; SHALL pop bundle on handshake of its last valid slot, next bundle visible the following cycle.
REQ-013 SHALL drive iretire_o=1 if compressed else 2, ilastsize_o=!compressed, iaddr_o=slot pc.
REQ-014 SHALL drive itype_o=0 on every record except the last of a bundle, which carries the event: 1 exception, 2 interrupt, 3 eret; priority exception>interrupt>eret.
REQ-015 SHALL, for an event bundle with no valid slot, emit exactly one record: iretire_o=0, ilastsize_o=0, iaddr_o=pc_i[0] captured, itype_o per REQ-014.
REQ-016 SHALL drive cause_o, tval_o, priv_o from the bundle on every record of it.
REQ-017 SHALL have output FSM states EMPTY (valid_o=0) and SERVE; EMPTY->SERVE when FIFO non-empty; SERVE->EMPTY on last-slot handshake with FIFO then empty; SERVE->SERVE otherwise.
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH; simultaneous push and pop when neither full nor empty keeps occupancy unchanged.

Reset
REQ-019 SHALL on rst_i=1 clear FIFO, slot pointer, FSM to EMPTY, overflow_o=0, drop_cnt_o=0, valid_o=0, all record outputs 0.
REQ-020 SHALL discard in-flight records on reset mid-bundle; no partial record after reset release; inputs ignored during reset.

Configuration
REQ-021 SHALL, with MURE_DROP_CNT_EN defined, increment drop_cnt_o on every dropped bundle, saturating at 16'hFFFF; without it, drop_cnt_o tied to 0 and no counter logic synthesised; overflow_o present in both.

Structure
REQ-022 SHALL take field widths and itype encodings from mure_pkg; mure_pkg SHALL define bundle struct (slot array + event flags + common fields) and itype enum.
REQ-023 SHALL instantiate one sub-module mure_bundle_fifo (DEPTH, dtype parameters, full/empty/push/pop/data); slot selection and FSM in top.

Verification
REQ-024 NRET=2, valid_i=2'b11, compressed_i=2'b01, pc 0x1000/0x1002, ready_i=1 -> two records: iaddr 0x1000 iretire 1, then 0x1002 iretire 2, itype 0 both.
REQ-025 valid_i=2'b10 with exception_i=1, cause 2 -> one record iaddr=pc_i[1], itype 1, cause_o 2.
REQ-026 valid_i=0, interrupt_i=1, cause 7 -> one record iretire 0, itype 2, iaddr=pc_i[0].
REQ-027 ready_i=0, push 17 bundles at DEPTH=16 -> overflow_o=1, drop_cnt_o=1 (macro on) or 0 (off), first record stable throughout.
REQ-028 rst_i=1 asserted after first of two slot handshakes -> next cycle valid_o=0, FIFO empty, no remaining slot emitted.
REQ-029 eret_i and exception_i together on valid_i=2'b11 -> last record itype 1, first itype 0.
